// File: rtl/dice_roll_gen.sv
// dice_roll_gen
//   Upstream stage of the dual-dice comparator. A user-stoppable LED chaser
//   provides the user face. Three further faces are drawn from a free-running
//   8-bit Fibonacci LFSR, using rejection sampling to get values in 1..6. All
//   four faces are registered. They stay stable until overwritten by a later
//   round. roll_valid pulses for one cycle when a round completes.
//
// Ports
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   start             in   begin a round (honoured in IDLE only)
//   stop              in   user stop press (honoured in CHASE only)
//   chase_led         out  [2:0] face currently shown by the chaser, 1..6
//   led_chaser_user   out  [2:0] face latched at stop
//   led_chaser_random out  [2:0] first LFSR face
//   random_number_1   out  [2:0] second LFSR face
//   random_number_2   out  [2:0] third LFSR face
//   roll_valid        out  one-cycle pulse, all four faces new and stable
//   busy              out  high in every state except IDLE
//
// Face value 0 means "no roll yet" and is never produced by a round.

module dice_roll_gen #(
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter int unsigned CHASE_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   output logic [2:0] chase_led,
   output logic [2:0] led_chaser_user,
   output logic [2:0] led_chaser_random,
   output logic [2:0] random_number_1,
   output logic [2:0] random_number_2,
   output logic       roll_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      CHASE,
      DRAW_R,
      DRAW_1,
      DRAW_2,
      DONE
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
   localparam logic [7:0] LFSR_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0] DIV_LAST  = 8'(CHASE_DIV - 1);

   state_t     state;
   logic [7:0] lfsr;
   logic [7:0] div;
   logic       lfsr_fb;
   logic [2:0] cand;
   logic       cand_ok;
   logic [2:0] chase_next;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign cand       = lfsr[2:0];
   assign cand_ok    = (cand != 3'd0) && (cand != 3'd7);
   assign chase_next = (chase_led == 3'd6) ? 3'd1 : chase_led + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         lfsr              <= LFSR_INIT;
         div               <= '0;
         chase_led         <= 3'd1;
         led_chaser_user   <= '0;
         led_chaser_random <= '0;
         random_number_1   <= '0;
         random_number_2   <= '0;
         roll_valid        <= 1'b0;
         busy              <= 1'b0;
      end else begin
         lfsr       <= {lfsr[6:0], lfsr_fb};
         roll_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               // start takes priority over a simultaneous stop
               if (start) begin
                  state     <= CHASE;
                  busy      <= 1'b1;
                  chase_led <= 3'd1;
                  div       <= '0;
               end
            end

            CHASE: begin
               if (div == DIV_LAST) begin
                  div       <= '0;
                  chase_led <= chase_next;
               end else begin
                  div <= div + 8'd1;
               end
               // Latch the face on display now. An advance on the same edge
               // does not affect the latched value.
               if (stop) begin
                  led_chaser_user <= chase_led;
                  state           <= DRAW_R;
               end
            end

            DRAW_R: begin
               if (cand_ok) begin
                  led_chaser_random <= cand;
                  state             <= DRAW_1;
               end
            end

            DRAW_1: begin
               if (cand_ok) begin
                  random_number_1 <= cand;
                  state           <= DRAW_2;
               end
            end

            DRAW_2: begin
               if (cand_ok) begin
                  random_number_2 <= cand;
                  state           <= DONE;
                  roll_valid      <= 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dice_roll_gen.sv
// tb_dice_roll_gen
//   Self-checking bench for dice_roll_gen. It drives stop-cycle vectors from a
//   table and uses hand-written sequences for reset, ignored inputs and
//   back-to-back rounds. Expected faces and latency come from a bench LFSR
//   model and are queued when stop is driven. They are popped and compared
//   when roll_valid appears.

module tb_dice_roll_gen;

   localparam int unsigned CHASE_DIV = 4;
   localparam int unsigned TIMEOUT   = 64;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [2:0] chase_led;
   logic [2:0] led_chaser_user;
   logic [2:0] led_chaser_random;
   logic [2:0] random_number_1;
   logic [2:0] random_number_2;
   logic       roll_valid;
   logic       busy;

   dice_roll_gen #(
      .LFSR_SEED (8'hA5),
      .CHASE_DIV (CHASE_DIV)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .stop              (stop),
      .chase_led         (chase_led),
      .led_chaser_user   (led_chaser_user),
      .led_chaser_random (led_chaser_random),
      .random_number_1   (random_number_1),
      .random_number_2   (random_number_2),
      .roll_valid        (roll_valid),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  user;
      logic [2:0]  r0;
      logic [2:0]  r1;
      logic [2:0]  r2;
      int unsigned latency;
   } exp_t;

   typedef struct {
      int unsigned stop_cycle;
      logic [2:0]  exp_user;
   } vec_t;

   exp_t sb[$];
   int   tests;
   int   fails;
   int   rolls;
   logic [7:0] model_lfsr;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Independent reference LFSR that tracks the DUT cycle by cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_lfsr <= 8'hA5;
      else        model_lfsr <= lfsr_step(model_lfsr);
   end

   always @(posedge clk) begin
      if (roll_valid) rolls <= rolls + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called with the DUT in CHASE. Stop is not yet asserted at this point.
   task automatic do_stop(input logic [2:0] exp_user, input bit poke_start);
      exp_t        e;
      exp_t        got;
      logic [7:0]  m;
      logic [2:0]  f [3];
      int unsigned rej;
      int unsigned n;
      bit          seen;
      // The DRAW_R candidate is the LFSR value just after the stop edge.
      m   = lfsr_step(model_lfsr);
      rej = 0;
      for (int i = 0; i < 3; i++) begin
         while (m[2:0] == 3'd0 || m[2:0] == 3'd7) begin
            m = lfsr_step(m);
            rej++;
         end
         f[i] = m[2:0];
         m    = lfsr_step(m);
      end
      e.user = exp_user; e.r0 = f[0]; e.r1 = f[1]; e.r2 = f[2];
      e.latency = 4 + rej;
      sb.push_back(e);

      stop = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (n < TIMEOUT && !seen) begin
         tick();
         n++;
         if (n == 1) begin
            stop = 1'b0;
            chk("busy_in_draw", int'(busy), 1);
         end
         if (poke_start) start = (n == 2);
         if (roll_valid) seen = 1'b1;
      end
      start = 1'b0;
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL roll_timeout: got no roll_valid within %0d cycles", TIMEOUT);
         void'(sb.pop_front());
      end else begin
         got = sb.pop_front();
         chk("latency",    int'(n),                 int'(got.latency));
         chk("user_face",  int'(led_chaser_user),   int'(got.user));
         chk("rand_face",  int'(led_chaser_random), int'(got.r0));
         chk("rand_num_1", int'(random_number_1),   int'(got.r1));
         chk("rand_num_2", int'(random_number_2),   int'(got.r2));
         chk("face_range", int'(led_chaser_random >= 3'd1 && led_chaser_random <= 3'd6 &&
                                random_number_1 >= 3'd1 && random_number_1 <= 3'd6 &&
                                random_number_2 >= 3'd1 && random_number_2 <= 3'd6), 1);
         tick();
         chk("roll_single", int'(roll_valid), 0);
         chk("busy_idle",   int'(busy),       0);
         tick();
         chk("hold_random", int'(led_chaser_random), int'(got.r0));
         chk("hold_user",   int'(led_chaser_user),   int'(got.user));
      end
   endtask

   // Start a round, stop in CHASE cycle stop_cycle and check the result.
   task automatic run_round(input int unsigned stop_cycle, input logic [2:0] exp_user);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int unsigned i = 0; i < stop_cycle; i++) tick();
      chk("chase_led", int'(chase_led), int'(exp_user));
      do_stop(exp_user, 1'b0);
   endtask

   initial begin
      vec_t       vecs [8];
      logic [2:0] prev_user;
      int         rolls_before;

      vecs[0] = '{10, 3'd3};
      vecs[1] = '{23, 3'd6};
      vecs[2] = '{24, 3'd1};
      vecs[3] = '{0,  3'd1};
      vecs[4] = '{3,  3'd1};
      vecs[5] = '{4,  3'd2};
      vecs[6] = '{47, 3'd6};
      vecs[7] = '{48, 3'd1};

      tests = 0; fails = 0; rolls = 0;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      tick(); tick();
      chk("rst_chase_led", int'(chase_led),         1);
      chk("rst_user",      int'(led_chaser_user),   0);
      chk("rst_random",    int'(led_chaser_random), 0);
      chk("rst_num_1",     int'(random_number_1),   0);
      chk("rst_num_2",     int'(random_number_2),   0);
      chk("rst_roll",      int'(roll_valid),        0);
      chk("rst_busy",      int'(busy),              0);
      rst_n = 1'b1;
      tick();

      // Table-driven chaser stops, including the wrap and coincident advance
      foreach (vecs[i]) run_round(vecs[i].stop_cycle, vecs[i].exp_user);

      // stop held high at CHASE entry gives user face 1
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("busy_held_stop", int'(busy), 1);
      do_stop(3'd1, 1'b0);

      // start and stop together in IDLE: chase starts and stop is not latched
      prev_user = led_chaser_user;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("both_busy", int'(busy), 1);
      for (int i = 0; i < 5; i++) tick();
      chk("both_no_latch", int'(led_chaser_user), int'(prev_user));
      chk("both_chase_led", int'(chase_led), 2);
      chk("both_no_roll", int'(roll_valid), 0);
      // A start pulse during the draw must be ignored
      do_stop(3'd2, 1'b1);

      // stop in IDLE has no effect
      prev_user = led_chaser_user;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("idle_stop_busy", int'(busy), 0);
      tick();
      chk("idle_stop_user", int'(led_chaser_user), int'(prev_user));

      // Reset in the middle of CHASE aborts the round immediately
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      rolls_before = rolls;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_chase_led", int'(chase_led),         1);
      chk("mid_rst_user",      int'(led_chaser_user),   0);
      chk("mid_rst_random",    int'(led_chaser_random), 0);
      chk("mid_rst_num_1",     int'(random_number_1),   0);
      chk("mid_rst_num_2",     int'(random_number_2),   0);
      chk("mid_rst_roll",      int'(roll_valid),        0);
      chk("mid_rst_busy",      int'(busy),              0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rst_no_roll", rolls - rolls_before, 0);
      // The LFSR restarts from the seed, which the model also restarts from.
      run_round(10, 3'd3);

      // Three back-to-back rounds
      rolls_before = rolls;
      run_round(5, 3'd2);
      run_round(13, 3'd4);
      run_round(17, 3'd5);
      tick();
      chk("b2b_roll_count", rolls - rolls_before, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
